// File: rtl/keycode_pkg.sv
// Shared register map and field positions for the keycode FIFO PIO.
package keycode_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_PEEK   = 2'd3
    } reg_addr_e;

    localparam int unsigned AVL_DW     = 32;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_LVL_LSB = 8;

    localparam int unsigned CT_FLUSH   = 0;
    localparam int unsigned CT_CLROVF  = 1;
    localparam int unsigned CT_IRQEN   = 2;

    // Level counter must hold 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/keycode_fifo_pio_if.sv
// Avalon-MM slave bus plus the keycode valid/ready stream.
interface keycode_fifo_pio_if #(
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] key_data;
    logic              key_valid;
    logic              key_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, key_ready,
        output readdata, key_data, key_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, key_ready,
        input  readdata, key_data, key_valid
    );
endinterface

// File: rtl/keycode_fifo_core.sv
// First-word-fall-through FIFO: storage, pointers and level tracking.
module keycode_fifo_core
    import keycode_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [lvl_width(DEPTH)-1:0]   level,
    output logic                          empty_nxt_c
);
    localparam int unsigned LVL_W = lvl_width(DEPTH);
    localparam int unsigned PTR_W = LVL_W - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Next level; flush overrides any push or pop.
    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level - LVL_W'(1);
        end
    end

    assign empty_nxt_c = (level_d == '0);

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode peripheral: register decode, legacy last-key, overflow and irq.
module keycode_fifo_pio
    import keycode_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    keycode_fifo_pio_if.slave  bus,
    output logic [DATA_W-1:0]  out_port,
    output logic               irq
);
    localparam int unsigned LVL_W = lvl_width(DEPTH);

    logic              wr;
    logic              wr_data;
    logic              wr_ctrl;
    logic              pop;
    logic              flush;
    logic              clr_ovf;
    logic              ovf_evt;
    logic              full;
    logic              empty;
    logic              empty_nxt;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] head;
    logic              overflow;
    logic              irq_en;
    logic              ovf_d;
    logic              irq_en_d;
    logic              unused_wdata;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_data  = wr & (bus.address == ADDR_DATA);
    assign wr_ctrl  = wr & (bus.address == ADDR_CTRL);
    assign pop      = ~empty & bus.key_ready;
    assign flush    = wr_ctrl & bus.writedata[CT_FLUSH];
    assign clr_ovf  = wr_ctrl & bus.writedata[CT_CLROVF];
    assign ovf_evt  = wr_data & full & ~pop;

    assign bus.key_valid = ~empty;
    assign bus.key_data  = head;
    assign unused_wdata  = ^bus.writedata;

    keycode_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (wr_data),
        .pop         (pop),
        .flush       (flush),
        .wr_data     (bus.writedata[DATA_W-1:0]),
        .rd_data     (head),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .empty_nxt_c (empty_nxt)
    );

    // Next overflow / irq_en; a set beats a clear in the same cycle.
    always_comb begin
        ovf_d    = overflow;
        irq_en_d = irq_en;
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
        if (wr_ctrl) irq_en_d = bus.writedata[CT_IRQEN];
    end

    // Control/status registers; irq tracks the post-update state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_data) out_port <= bus.writedata[DATA_W-1:0];
            overflow <= ovf_d;
            irq_en   <= irq_en_d;
            irq      <= irq_en_d & (ovf_d | ~empty_nxt);
        end
    end

    // Zero-wait read mux, decoded from address alone.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = AVL_DW'(out_port);
            ADDR_STATUS: begin
                bus.readdata[ST_EMPTY]               = empty;
                bus.readdata[ST_FULL]                = full;
                bus.readdata[ST_OVF]                 = overflow;
                bus.readdata[ST_LVL_LSB +: LVL_W]    = level;
            end
            ADDR_CTRL:   bus.readdata[CT_IRQEN] = irq_en;
            default:     bus.readdata = AVL_DW'(head);
        endcase
    end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Randomised self-checking bench for keycode_fifo_pio against a queue model.
module tb_keycode_fifo_pio;
    import keycode_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] out_port;
    logic              irq;

    keycode_fifo_pio_if #(.DATA_W(DATA_W)) bus ();

    keycode_fifo_pio #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is just a queue plus a few flags.
    logic [7:0] mq [$];
    logic [7:0] m_last;
    logic       m_ovf;
    logic       m_irqen;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size()) << 8;
        if (mq.size() == 0)     s = s | 32'h1;
        if (mq.size() == DEPTH) s = s | 32'h2;
        if (m_ovf)              s = s | 32'h4;
        return s;
    endfunction

    function automatic logic m_irq();
        return m_irqen && (m_ovf || mq.size() != 0);
    endfunction

    function automatic logic [7:0] m_head();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last  = 8'h00;
        m_ovf   = 1'b0;
        m_irqen = 1'b0;
    endtask

    // One clock of stimulus; the model advances on the same edge.
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] wd, input logic rdy);
        int sz;
        logic p;
        @(negedge clk);
        bus.chipselect = w;
        bus.write_n    = ~w;
        bus.address    = a;
        bus.writedata  = wd;
        bus.key_ready  = rdy;
        @(posedge clk);
        sz = mq.size();
        p  = rdy && (sz > 0);
        if (w && a == 2'd2 && wd[0]) begin
            mq.delete();
        end else begin
            if (p) void'(mq.pop_front());
            if (w && a == 2'd0) begin
                if (sz < DEPTH || p) mq.push_back(wd[7:0]);
                else m_ovf = 1'b1;
            end
        end
        if (w && a == 2'd0) m_last = wd[7:0];
        if (w && a == 2'd2) begin
            if (wd[1]) m_ovf = 1'b0;
            m_irqen = wd[2];
        end
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.key_ready  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset key_valid: got %b want 0", bus.key_valid); end
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset out_port: got %h want 00", out_port); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset irq: got %b want 0", irq); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset status: got %h want 00000001", d); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_push();
        logic [31:0] d;
        step(1'b1, 2'd0, 32'h0000_001A, 1'b0);
        checks++; if (out_port !== 8'h1A) begin errors++; $display("FAIL single out_port: got %h want 1a", out_port); end
        checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL single key_valid: got %b want 1", bus.key_valid); end
        checks++; if (bus.key_data !== 8'h1A) begin errors++; $display("FAIL single key_data: got %h want 1a", bus.key_data); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL single status: got %h want 00000100", d); end
        rd(2'd3, d);
        checks++; if (d !== 32'h0000_001A) begin errors++; $display("FAIL single peek: got %h want 0000001a", d); end
        step(1'b0, 2'd0, 32'h0, 1'b1);
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL single drained key_valid: got %b want 0", bus.key_valid); end
        rd(2'd0, d);
        checks++; if (d !== 32'h0000_001A) begin errors++; $display("FAIL single data readback: got %h want 0000001a", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int n;
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'(8'h04 + i), 1'b0);
        step(1'b1, 2'd0, 32'h0000_002C, 1'b0);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0806) begin errors++; $display("FAIL ovf status: got %h want 00000806", d); end
        checks++; if (out_port !== 8'h2C) begin errors++; $display("FAIL ovf out_port: got %h want 2c", out_port); end
        n = 0;
        for (int i = 0; i < 12 && bus.key_valid === 1'b1; i++) begin
            checks++; if (bus.key_data !== 8'(8'h04 + i)) begin errors++; $display("FAIL ovf drain[%0d]: got %h want %h", i, bus.key_data, 8'(8'h04 + i)); end
            step(1'b0, 2'd0, 32'h0, 1'b1);
            n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL ovf drain count: got %0d want 8", n); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0005) begin errors++; $display("FAIL ovf sticky status: got %h want 00000005", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq disabled: got %b want 0", irq); end
        step(1'b1, 2'd2, 32'h4, 1'b0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq on overflow: got %b want 1", irq); end
        step(1'b1, 2'd2, 32'h2, 1'b0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq after clear: got %b want 0", irq); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL irq status after clear: got %h want 00000001", d); end
        step(1'b1, 2'd2, 32'h4, 1'b0);
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL irq ctrl readback: got %h want 00000004", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq enabled idle: got %b want 0", irq); end
        step(1'b1, 2'd0, 32'h0000_0055, 1'b0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq on nonempty: got %b want 1", irq); end
        step(1'b0, 2'd0, 32'h0, 1'b1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq after drain: got %b want 0", irq); end
        step(1'b1, 2'd2, 32'h0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  last;
        int n;
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'($urandom_range(0, 255)), 1'b0);
        step(1'b1, 2'd0, 32'h0000_0016, 1'b1);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0802) begin errors++; $display("FAIL fullpp status: got %h want 00000802", d); end
        n = 0;
        last = 8'h00;
        for (int i = 0; i < 12 && mq.size() != 0; i++) begin
            checks++; if (bus.key_data !== m_head()) begin errors++; $display("FAIL fullpp drain[%0d]: got %h want %h", i, bus.key_data, m_head()); end
            last = bus.key_data;
            step(1'b0, 2'd0, 32'h0, 1'b1);
            n++;
        end
        checks++; if (last !== 8'h16 || n != 8) begin errors++; $display("FAIL fullpp last: got %h/%0d want 16/8", last, n); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        step(1'b1, 2'd0, 32'h31, 1'b0);
        step(1'b1, 2'd0, 32'h32, 1'b0);
        step(1'b1, 2'd0, 32'h33, 1'b0);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0300) begin errors++; $display("FAIL flush pre status: got %h want 00000300", d); end
        step(1'b1, 2'd2, 32'h1, 1'b1);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush status: got %h want 00000001", d); end
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL flush key_valid: got %b want 0", bus.key_valid); end
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL flush peek: got %h want 0", d); end
        checks++; if (out_port !== 8'h33) begin errors++; $display("FAIL flush out_port: got %h want 33", out_port); end
        step(1'b1, 2'd0, 32'h44, 1'b0);
        checks++; if (bus.key_data !== 8'h44) begin errors++; $display("FAIL flush refill head: got %h want 44", bus.key_data); end
        step(1'b0, 2'd0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] wd;
        logic [1:0]  a;
        logic        w;
        int r;
        for (int i = 0; i < 300; i++) begin
            checks++; if (bus.key_data !== m_head()) begin errors++; $display("FAIL rand head[%0d]: got %h want %h", i, bus.key_data, m_head()); end
            r  = $urandom_range(0, 99);
            wd = $urandom();
            w  = 1'b1;
            a  = 2'd0;
            if (r < 45)      a = 2'd0;
            else if (r < 49) a = 2'd2;
            else if (r < 53) a = 2'(1 + 2 * $urandom_range(0, 1));
            else             w = 1'b0;
            step(w, a, wd, ($urandom_range(0, 2) == 0));
            checks++; if (bus.key_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand valid[%0d]: got %b want %b", i, bus.key_valid, mq.size() != 0); end
            checks++; if (out_port !== m_last) begin errors++; $display("FAIL rand out_port[%0d]: got %h want %h", i, out_port, m_last); end
            checks++; if (irq !== m_irq()) begin errors++; $display("FAIL rand irq[%0d]: got %b want %b", i, irq, m_irq()); end
            rd(2'd1, d);
            checks++; if (d !== m_status()) begin errors++; $display("FAIL rand status[%0d]: got %h want %h", i, d, m_status()); end
            rd(2'd3, d);
            checks++; if (d !== 32'(m_head())) begin errors++; $display("FAIL rand peek[%0d]: got %h want %h", i, d, m_head()); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        step(1'b1, 2'd2, 32'h4, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'(8'h60 + i), 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.key_data !== m_head()) begin errors++; $display("FAIL arst drain[%0d]: got %h want %h", i, bus.key_data, m_head()); end
            step(1'b0, 2'd0, 32'h0, 1'b1);
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst pre irq: got %b want 1", irq); end
        @(negedge clk);
        bus.key_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL arst key_valid: got %b want 0", bus.key_valid); end
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL arst out_port: got %h want 00", out_port); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst irq: got %b want 0", irq); end
        bus.key_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL arst status: got %h want 00000001", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst ctrl: got %h want 0", d); end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        bus.key_ready  = 1'b0;
        test_reset();
        test_single_push();
        test_overflow();
        test_irq();
        test_full_push_pop();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
